// File: rtl/spi_xfer_seq_if.sv
// SPI master side of the transaction sequencer: chip select, byte
// handshake and data toward/from spi_master.
interface spi_xfer_seq_if #(
    parameter int d_width = 8
);
    logic               csn;
    logic               spi_enable;
    logic [d_width-1:0] spi_tx_data;
    logic               spi_busy;
    logic [d_width-1:0] spi_rx_data;

    modport master (
        output csn, spi_enable, spi_tx_data,
        input  spi_busy, spi_rx_data
    );

    modport slave (
        input  csn, spi_enable, spi_tx_data,
        output spi_busy, spi_rx_data
    );
endinterface

// File: rtl/spi_xfer_seq.sv
// Multi-byte SPI transaction sequencer: frames csn, feeds TX buffer bytes
// into spi_master and captures each returned byte into an RX buffer.
module spi_xfer_seq #(
    parameter int d_width   = 8,
    parameter int MAX_BYTES = 33,
    parameter int CS_SETUP  = 4,
    parameter int CS_HOLD   = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [5:0]         xfer_len,
    input  logic               tx_we,
    input  logic [5:0]         tx_addr,
    input  logic [d_width-1:0] tx_wdata,
    input  logic [5:0]         rx_addr,
    output logic [d_width-1:0] rx_rdata,
    output logic               seq_busy,
    output logic               done,
    output logic               err,
    spi_xfer_seq_if.master     spi
);
    typedef enum logic [2:0] {
        IDLE, SETUP, LOAD, WAIT_HI, WAIT_LO, STORE, HOLD, DONE
    } state_t;

    state_t state, state_nx;

    logic [d_width-1:0] txbuf [MAX_BYTES];
    logic [d_width-1:0] rxbuf [MAX_BYTES];

    logic [5:0] len;
    logic [5:0] idx;
    logic [7:0] cnt;
    logic       abort;

    logic len_ok, last, setup_end, hold_end, tmo;

    assign len_ok    = (xfer_len != 6'd0) && (xfer_len <= 6'(MAX_BYTES));
    assign last      = (idx == len - 6'd1);
    // SETUP plus the LOAD cycle give CS_SETUP cycles before spi_enable;
    // STORE, HOLD and the DONE edge give CS_HOLD cycles after busy falls.
    assign setup_end = (cnt == 8'(CS_SETUP - 2));
    assign hold_end  = (cnt == 8'(CS_HOLD - 3));
    assign tmo       = (cnt == 8'(TIMEOUT - 1));
    assign seq_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start && len_ok) state_nx = SETUP;
            SETUP:   if (setup_end) state_nx = LOAD;
            LOAD:    state_nx = WAIT_HI;
            WAIT_HI: begin
                if (spi.spi_busy) state_nx = WAIT_LO;
                else if (tmo)     state_nx = HOLD;
            end
            WAIT_LO: if (!spi.spi_busy) state_nx = STORE;
            STORE:   state_nx = last ? HOLD : LOAD;
            HOLD:    if (hold_end) state_nx = DONE;
            DONE:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spi.csn         <= 1'b1;
            spi.spi_enable  <= 1'b0;
            spi.spi_tx_data <= '0;
            done            <= 1'b0;
            err             <= 1'b0;
            idx             <= '0;
            len             <= '0;
            cnt             <= '0;
            abort           <= 1'b0;
            rx_rdata        <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            cnt  <= (state_nx != state) ? 8'd0 : cnt + 8'd1;
            rx_rdata <= (rx_addr < 6'(MAX_BYTES)) ? rxbuf[rx_addr] : '0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len     <= xfer_len;
                            idx     <= '0;
                            spi.csn <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    spi.spi_tx_data <= txbuf[idx];
                    spi.spi_enable  <= 1'b1;
                end
                WAIT_HI: begin
                    if (spi.spi_busy || tmo) spi.spi_enable <= 1'b0;
                    if (!spi.spi_busy && tmo) abort <= 1'b1;
                end
                STORE: if (!last) idx <= idx + 6'd1;
                HOLD: begin
                    if (hold_end) begin
                        spi.csn <= 1'b1;
                        done    <= !abort;
                        err     <= abort;
                    end
                end
                DONE: abort <= 1'b0;
                default: ;
            endcase
        end
    end

    // Buffers are deliberately not reset.
    always_ff @(posedge clk) begin
        if (tx_we && !seq_busy && (tx_addr < 6'(MAX_BYTES)))
            txbuf[tx_addr] <= tx_wdata;
        if (state == STORE)
            rxbuf[idx] <= spi.spi_rx_data;
    end
endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed bench for spi_xfer_seq with a loopback spi_master model
// (returns the previously shifted byte, busy for 16 cycles).
module tb_spi_xfer_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [5:0] xfer_len = '0;
    logic       tx_we = 1'b0;
    logic [5:0] tx_addr = '0;
    logic [7:0] tx_wdata = '0;
    logic [5:0] rx_addr = '0;
    logic [7:0] rx_rdata;
    logic       seq_busy, done, err;

    spi_xfer_seq_if #(.d_width(8)) spi ();

    spi_xfer_seq dut (
        .clk(clk), .reset(reset), .start(start), .xfer_len(xfer_len),
        .tx_we(tx_we), .tx_addr(tx_addr), .tx_wdata(tx_wdata),
        .rx_addr(rx_addr), .rx_rdata(rx_rdata),
        .seq_busy(seq_busy), .done(done), .err(err), .spi(spi)
    );

    always #5 clk = ~clk;

    // loopback spi_master model
    logic       stuck = 1'b0;
    logic [7:0] prev = 8'h00;
    logic [7:0] cur = 8'h00;
    int         mcnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            spi.spi_busy    <= 1'b0;
            spi.spi_rx_data <= 8'h00;
            mcnt            <= 0;
        end else if (spi.spi_busy) begin
            if (mcnt == 15) begin
                spi.spi_busy    <= 1'b0;
                spi.spi_rx_data <= prev;
                prev            <= cur;
            end
            mcnt <= mcnt + 1;
        end else if (spi.spi_enable && !stuck) begin
            spi.spi_busy <= 1'b1;
            mcnt         <= 0;
            cur          <= spi.spi_tx_data;
        end
    end

    // event monitor
    int cyc = 0, n_en = 0, n_csn_fall = 0, n_done = 0, n_err = 0, n_sb = 0;
    int en_hi = 0, en_since = 0;
    int t_csn_fall = 0, t_csn_rise = 0, t_first_en = 0, t_bfall = 0;
    logic csn_q = 1'b1, en_q = 1'b0, bsy_q = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (csn_q && !spi.csn) begin
            n_csn_fall++;
            t_csn_fall = cyc;
            en_since = 0;
        end
        if (!csn_q && spi.csn) t_csn_rise = cyc;
        if (!en_q && spi.spi_enable) begin
            n_en++;
            if (en_since == 0) t_first_en = cyc;
            en_since++;
        end
        if (spi.spi_enable) en_hi++;
        if (bsy_q && !spi.spi_busy) t_bfall = cyc;
        if (done) n_done++;
        if (err) n_err++;
        if (seq_busy) n_sb++;
        csn_q = spi.csn;
        en_q  = spi.spi_enable;
        bsy_q = spi.spi_busy;
    end

    int n_run = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr_tx(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        tx_we = 1'b1; tx_addr = a; tx_wdata = d;
        @(negedge clk);
        tx_we = 1'b0;
    endtask

    task automatic rd_rx(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        rx_addr = a;
        @(negedge clk);
        d = rx_rdata;
    endtask

    task automatic go(input logic [5:0] n);
        @(negedge clk);
        start = 1'b1; xfer_len = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (seq_busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, seq_busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] d;
    int b_en, b_csn, b_done, b_err, b_sb, b_hi;

    task automatic snap();
        b_en = n_en; b_csn = n_csn_fall; b_done = n_done;
        b_err = n_err; b_sb = n_sb; b_hi = en_hi;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_csn", {31'd0, spi.csn}, 1);
        chk("rst_en", {31'd0, spi.spi_enable}, 0);
        chk("rst_txd", {24'd0, spi.spi_tx_data}, 0);
        chk("rst_busy", {31'd0, seq_busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_rdata", {24'd0, rx_rdata}, 0);

        // two-byte loopback
        wr_tx(6'd0, 8'h20);
        wr_tx(6'd1, 8'h0B);
        snap();
        go(6'd2);
        wait_idle("t1_to");
        chk("t1_en", n_en - b_en, 2);
        chk("t1_csn", n_csn_fall - b_csn, 1);
        chk("t1_done", n_done - b_done, 1);
        chk("t1_err", n_err - b_err, 0);
        rd_rx(6'd0, d); chk("t1_rx0", {24'd0, d}, 32'h00);
        rd_rx(6'd1, d); chk("t1_rx1", {24'd0, d}, 32'h20);

        // full 33-byte burst
        for (int i = 0; i < 33; i++) wr_tx(6'(i), 8'(i));
        snap();
        go(6'd33);
        wait_idle("t2_to");
        chk("t2_en", n_en - b_en, 33);
        chk("t2_csn", n_csn_fall - b_csn, 1);
        chk("t2_done", n_done - b_done, 1);
        chk("t2_setup", t_first_en - t_csn_fall, 4);
        chk("t2_hold", t_csn_rise - t_bfall, 4);
        rd_rx(6'd0, d); chk("t2_rx0", {24'd0, d}, 32'h0B);
        for (int i = 1; i < 33; i++) begin
            rd_rx(6'(i), d);
            chk($sformatf("t2_rx%0d", i), {24'd0, d}, 32'(i - 1));
        end
        rd_rx(6'd40, d); chk("t2_oob", {24'd0, d}, 0);

        // illegal lengths
        snap();
        go(6'd0);
        repeat (3) @(negedge clk);
        chk("t3_err0", n_err - b_err, 1);
        go(6'd34);
        repeat (3) @(negedge clk);
        chk("t3_err34", n_err - b_err, 2);
        chk("t3_csn", n_csn_fall - b_csn, 0);
        chk("t3_en", n_en - b_en, 0);
        chk("t3_busy", n_sb - b_sb, 0);
        chk("t3_csn1", {31'd0, spi.csn}, 1);

        // busy never rises: timeout
        wr_tx(6'd0, 8'h55);
        stuck = 1'b1;
        snap();
        go(6'd1);
        wait_idle("t4_to");
        chk("t4_enhi", en_hi - b_hi, 64);
        chk("t4_err", n_err - b_err, 1);
        chk("t4_done", n_done - b_done, 0);
        chk("t4_csn", {31'd0, spi.csn}, 1);
        stuck = 1'b0;
        snap();
        go(6'd1);
        wait_idle("t4b_to");
        chk("t4b_done", n_done - b_done, 1);
        chk("t4b_err", n_err - b_err, 0);
        rd_rx(6'd0, d); chk("t4b_rx0", {24'd0, d}, 32'h20);

        // reset during WAIT_LO of byte 3 of 5
        for (int i = 0; i < 5; i++) wr_tx(6'(i), 8'hA0 + 8'(i));
        snap();
        go(6'd5);
        begin
            int k = 0;
            while (!((n_en - b_en) == 3 && spi.spi_busy && !spi.spi_enable)
                   && k < 500) begin
                @(negedge clk);
                k++;
            end
            chk("t5_reach", k < 500, 1);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("t5_csn", {31'd0, spi.csn}, 1);
        chk("t5_en", {31'd0, spi.spi_enable}, 0);
        chk("t5_busy", {31'd0, seq_busy}, 0);
        reset = 1'b0;
        snap();
        go(6'd2);
        wait_idle("t5b_to");
        chk("t5b_done", n_done - b_done, 1);
        rd_rx(6'd0, d); chk("t5b_rx0", {24'd0, d}, 32'hA1);
        rd_rx(6'd1, d); chk("t5b_rx1", {24'd0, d}, 32'hA0);

        // tx_we and restart while busy are ignored
        wr_tx(6'd0, 8'h11);
        wr_tx(6'd1, 8'h22);
        wr_tx(6'd2, 8'h33);
        snap();
        go(6'd3);
        repeat (10) @(negedge clk);
        tx_we = 1'b1; tx_addr = 6'd0; tx_wdata = 8'hEE;
        start = 1'b1; xfer_len = 6'd3;
        @(negedge clk);
        tx_we = 1'b0; start = 1'b0;
        wait_idle("t6_to");
        chk("t6_done", n_done - b_done, 1);
        chk("t6_err", n_err - b_err, 0);
        rd_rx(6'd0, d); chk("t6_rx0", {24'd0, d}, 32'hA1);
        rd_rx(6'd1, d); chk("t6_rx1", {24'd0, d}, 32'h11);
        rd_rx(6'd2, d); chk("t6_rx2", {24'd0, d}, 32'h22);
        go(6'd3);
        wait_idle("t6b_to");
        rd_rx(6'd0, d); chk("t6b_rx0", {24'd0, d}, 32'h33);
        rd_rx(6'd1, d); chk("t6b_rx1", {24'd0, d}, 32'h11);
        rd_rx(6'd2, d); chk("t6b_rx2", {24'd0, d}, 32'h22);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
